// File: rtl/calc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : calc_mem_responder
// Description : Controller-slave word memory with a lower-priority host port,
//               registered read data, sticky out-of-range flag and saturating
//               access counters. Define CALC_MEM_FWD_EN for write-first
//               forwarding on same-address controller read/write.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_mem_responder #(
    parameter int ADDR_W        = 10,
    parameter int MEM_WORD_SIZE = 64,
    parameter int DEPTH         = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        r_addr,
    output logic [MEM_WORD_SIZE-1:0] r_data,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [MEM_WORD_SIZE-1:0] w_data,
    input  logic                     host_en,
    input  logic                     host_we,
    input  logic [ADDR_W-1:0]        host_addr,
    input  logic [MEM_WORD_SIZE-1:0] host_wdata,
    output logic                     host_gnt,
    output logic [MEM_WORD_SIZE-1:0] host_rdata,
    output logic                     oob_err,
    output logic [15:0]              rd_count,
    output logic [15:0]              wr_count
);

    localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [15:0]     c_CNT_MAX = 16'hFFFF;

    logic [MEM_WORD_SIZE-1:0] mem_q [DEPTH];

    logic [MEM_WORD_SIZE-1:0] r_data_q, r_data_d;
    logic [MEM_WORD_SIZE-1:0] host_rdata_q, host_rdata_d;
    logic                     oob_err_q, oob_err_d;
    logic [15:0]              rd_count_q, rd_count_d;
    logic [15:0]              wr_count_q, wr_count_d;

    logic                     w_r_in, w_w_in, w_h_in;
    logic                     w_host_gnt;
    logic                     w_mem_we;
    logic [c_IDX_W-1:0]       w_mem_idx;
    logic [MEM_WORD_SIZE-1:0] w_mem_wdata;

    // Range checks are done on the full address so aliasing above DEPTH is impossible.
    assign w_r_in = ({1'b0, r_addr}    < c_DEPTH);
    assign w_w_in = ({1'b0, w_addr}    < c_DEPTH);
    assign w_h_in = ({1'b0, host_addr} < c_DEPTH);

    assign w_host_gnt = host_en & ~read & ~write;

    // A granted host access never coincides with a controller write, so one write port suffices.
    assign w_mem_we    = (write & w_w_in) | (w_host_gnt & host_we & w_h_in);
    assign w_mem_idx   = write ? w_addr[c_IDX_W-1:0] : host_addr[c_IDX_W-1:0];
    assign w_mem_wdata = write ? w_data : host_wdata;

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_mem_we) begin
            mem_q[w_mem_idx] <= w_mem_wdata;
        end
    end

    always_comb begin
        r_data_d = r_data_q;
        if (read) begin
            if (!w_r_in) begin
                r_data_d = '0;
            end
`ifdef CALC_MEM_FWD_EN
            else if (write && (w_addr == r_addr)) begin
                r_data_d = w_data;
            end
`endif
            else begin
                r_data_d = mem_q[r_addr[c_IDX_W-1:0]];
            end
        end

        host_rdata_d = host_rdata_q;
        if (w_host_gnt && !host_we) begin
            host_rdata_d = w_h_in ? mem_q[host_addr[c_IDX_W-1:0]] : '0;
        end

        oob_err_d = oob_err_q | (read & ~w_r_in) | (write & ~w_w_in)
                  | (w_host_gnt & ~w_h_in);

        rd_count_d = (read  && (rd_count_q != c_CNT_MAX)) ? rd_count_q + 16'd1 : rd_count_q;
        wr_count_d = (write && (wr_count_q != c_CNT_MAX)) ? wr_count_q + 16'd1 : wr_count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data_q     <= '0;
            host_rdata_q <= '0;
            oob_err_q    <= 1'b0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
        end else begin
            r_data_q     <= r_data_d;
            host_rdata_q <= host_rdata_d;
            oob_err_q    <= oob_err_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign r_data     = r_data_q;
    assign host_rdata = host_rdata_q;
    assign host_gnt   = w_host_gnt;
    assign oob_err    = oob_err_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_mem_responder
// Description : Table-driven scoreboard bench for calc_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_mem_responder;

    localparam int ADDR_W = 10;
    localparam int W      = 64;
    localparam int DEPTH  = 512;
    localparam logic [W-1:0] c_H = 64'h1111_2222_3333_4444;
`ifdef CALC_MEM_FWD_EN
    localparam logic [W-1:0] c_SAME_EXP = 64'h20;
`else
    localparam logic [W-1:0] c_SAME_EXP = 64'h10;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              read, write, host_en, host_we;
    logic [ADDR_W-1:0] r_addr, w_addr, host_addr;
    logic [W-1:0]      w_data, host_wdata, r_data, host_rdata;
    logic              host_gnt, oob_err;
    logic [15:0]       rd_count, wr_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic              read;
        logic [ADDR_W-1:0] r_addr;
        logic              write;
        logic [ADDR_W-1:0] w_addr;
        logic [W-1:0]      w_data;
        logic              host_en;
        logic              host_we;
        logic [ADDR_W-1:0] host_addr;
        logic [W-1:0]      host_wdata;
        logic              exp_gnt;
        logic [W-1:0]      exp_r;
        logic [W-1:0]      exp_h;
        logic [15:0]       exp_rd;
        logic [15:0]       exp_wr;
        logic              exp_oob;
    } vec_t;

    logic [W-1:0] exp_r_q [$];
    logic [W-1:0] exp_h_q [$];

    calc_mem_responder #(.ADDR_W(ADDR_W), .MEM_WORD_SIZE(W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .read(read), .r_addr(r_addr), .r_data(r_data),
        .write(write), .w_addr(w_addr), .w_data(w_data),
        .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .oob_err(oob_err), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        read = 0; r_addr = '0; write = 0; w_addr = '0; w_data = '0;
        host_en = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    function automatic vec_t mk(input logic rd, input int ra, input logic wr, input int wa,
                                input logic [W-1:0] wd, input logic he, input logic hw,
                                input int ha, input logic [W-1:0] hd, input logic eg,
                                input logic [W-1:0] er, input logic [W-1:0] eh,
                                input int erd, input int ewr, input logic eo);
        vec_t v;
        v.read = rd; v.r_addr = ADDR_W'(ra); v.write = wr; v.w_addr = ADDR_W'(wa);
        v.w_data = wd; v.host_en = he; v.host_we = hw; v.host_addr = ADDR_W'(ha);
        v.host_wdata = hd; v.exp_gnt = eg; v.exp_r = er; v.exp_h = eh;
        v.exp_rd = 16'(erd); v.exp_wr = 16'(ewr); v.exp_oob = eo;
        return v;
    endfunction

    // Drives one vector for one clock; expected read data goes through the scoreboard.
    task automatic apply(input vec_t v);
        read = v.read; r_addr = v.r_addr; write = v.write; w_addr = v.w_addr;
        w_data = v.w_data; host_en = v.host_en; host_we = v.host_we;
        host_addr = v.host_addr; host_wdata = v.host_wdata;
        #1;
        chk("host_gnt", W'(host_gnt), W'(v.exp_gnt));
        if (v.read) exp_r_q.push_back(v.exp_r);
        if (v.host_en && v.exp_gnt && !v.host_we) exp_h_q.push_back(v.exp_h);
        @(posedge clk_i);
        #1;
        idle();
        if (exp_r_q.size() > 0) chk("r_data", r_data, exp_r_q.pop_front());
        if (exp_h_q.size() > 0) chk("host_rdata", host_rdata, exp_h_q.pop_front());
        chk("rd_count", W'(rd_count), W'(v.exp_rd));
        chk("wr_count", W'(wr_count), W'(v.exp_wr));
        chk("oob_err", W'(oob_err), W'(v.exp_oob));
    endtask

    vec_t tbl [16];

    initial begin
        //            rd ra  wr wa   wdata   he hw ha   hdata    gnt exp_r       exp_h rd wr oob
        tbl[0]  = mk(0, 0,   0, 0,   0,      1, 1, 3,   c_H,     1,  0,          0,    0, 0, 0);
        tbl[1]  = mk(1, 3,   0, 0,   0,      0, 0, 0,   0,       0,  c_H,        0,    1, 0, 0);
        tbl[2]  = mk(0, 0,   1, 5,   'hA5,   1, 1, 5,   'hDEAD,  0,  0,          0,    1, 1, 0);
        tbl[3]  = mk(1, 5,   0, 0,   0,      1, 0, 3,   0,       0,  'hA5,       0,    2, 1, 0);
        tbl[4]  = mk(0, 0,   0, 0,   0,      1, 0, 3,   0,       1,  0,          c_H,  2, 1, 0);
        tbl[5]  = mk(0, 0,   1, 7,   'h10,   0, 0, 0,   0,       0,  0,          0,    2, 2, 0);
        tbl[6]  = mk(1, 7,   1, 7,   'h20,   0, 0, 0,   0,       0,  c_SAME_EXP, 0,    3, 3, 0);
        tbl[7]  = mk(1, 7,   0, 0,   0,      0, 0, 0,   0,       0,  'h20,       0,    4, 3, 0);
        tbl[8]  = mk(1, 3,   1, 12,  'h12,   0, 0, 0,   0,       0,  c_H,        0,    5, 4, 0);
        tbl[9]  = mk(1, 12,  0, 0,   0,      0, 0, 0,   0,       0,  'h12,       0,    6, 4, 0);
        tbl[10] = mk(0, 0,   1, 88,  'h88,   0, 0, 0,   0,       0,  0,          0,    6, 5, 0);
        tbl[11] = mk(1, 600, 0, 0,   0,      0, 0, 0,   0,       0,  0,          0,    7, 5, 1);
        tbl[12] = mk(0, 0,   1, 600, 'h99,   0, 0, 0,   0,       0,  0,          0,    7, 6, 1);
        tbl[13] = mk(1, 88,  0, 0,   0,      0, 0, 0,   0,       0,  'h88,       0,    8, 6, 1);
        tbl[14] = mk(0, 0,   0, 0,   0,      1, 1, 700, 'h77,    1,  0,          0,    8, 6, 1);
        tbl[15] = mk(0, 0,   0, 0,   0,      1, 0, 700, 0,       1,  0,          0,    8, 6, 1);

        idle();
        rst_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        host_en = 1;
        #1;
        chk("reset host_gnt", W'(host_gnt), W'(1'b1));
        chk("reset r_data", r_data, '0);
        chk("reset host_rdata", host_rdata, '0);
        chk("reset oob_err", W'(oob_err), '0);
        chk("reset rd_count", W'(rd_count), '0);
        chk("reset wr_count", W'(wr_count), '0);
        idle();
        rst_i = 0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 16; i++) apply(tbl[i]);

        // Saturation: run the read counter up to 0xFFFE, then three more reads.
        read = 1; r_addr = 3;
        repeat (16'hFFFE - 8) @(posedge clk_i);
        #1;
        chk("rd_count near max", W'(rd_count), W'(16'hFFFE));
        repeat (3) @(posedge clk_i);
        #1;
        idle();
        chk("rd_count saturated", W'(rd_count), W'(16'hFFFF));

        // Reset coinciding with accesses: write is discarded, contents survive.
        apply(mk(0, 0, 1, 9, 'h9A, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 7, 1));
        rst_i = 1; write = 1; w_addr = 9; w_data = 'h999; read = 1; r_addr = 3;
        @(posedge clk_i);
        #1;
        rst_i = 0;
        idle();
        chk("mid-reset r_data", r_data, '0);
        chk("mid-reset host_rdata", host_rdata, '0);
        chk("mid-reset oob_err", W'(oob_err), '0);
        chk("mid-reset rd_count", W'(rd_count), '0);
        chk("mid-reset wr_count", W'(wr_count), '0);
        apply(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 'h9A, 0, 1, 0, 0));
        apply(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, c_H,  0, 2, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
